monitor_verdict_collector: RTL and testbench

Consumer-side companion to the cluster monitors. Samples the per-property verdict flags (`ltlNcM`) a monitor cluster produces from the symbol stream and timestamps every verdict event. Buffers events in a small FIFO, which the CSR/debug unit drains over a valid/ready handshake. Also keeps sticky per-property status and an overflow flag.

---
 rtl/monitor_verdict_collector.sv | 130 +++++++++++++
 tb/tb_monitor_verdict_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_verdict_collector.sv
// monitor_verdict_collector
// Samples the per-property verdict flags of a monitor cluster, timestamps every
// verdict event and buffers the events in a small FIFO. The CSR/debug unit drains
// the FIFO over a valid/ready handshake. The block also keeps a sticky
// per-property status vector and an overflow flag.
//
// Optional feature: define VERDICT_EDGE_DETECT_EN to record only rising edges of
// each verdict. When it is defined, a held verdict produces one record. When it is
// left undefined, every run cycle with a non-zero verdict vector produces a record.
//
// DEPTH must be a power of two and at least 2. The pointers rely on natural
// wrap-around at that size.

module monitor_verdict_collector #(
    parameter int NUM_PROPS = 10,
    parameter int TS_W      = 16,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [NUM_PROPS-1:0]   ltl_in,
    input  logic                   clear_sticky,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [NUM_PROPS-1:0]   rec_props,
    output logic [TS_W-1:0]        rec_ts,
    output logic [NUM_PROPS-1:0]   sticky,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TS_W-1:0]      ts;
    logic [NUM_PROPS-1:0] ev;
    logic                 is_event;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [NUM_PROPS-1:0] props_mem [DEPTH];
    logic [TS_W-1:0]      ts_mem    [DEPTH];

`ifdef VERDICT_EDGE_DETECT_EN
    logic [NUM_PROPS-1:0] prev;

    // Remember the verdicts seen on the last run cycle so that only rising edges count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else if (run) begin
            prev <= ltl_in;
        end
    end

    assign ev = run ? (ltl_in & ~prev) : '0;
`else
    assign ev = run ? ltl_in : '0;
`endif

    assign is_event  = |ev;
    assign rec_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = rec_valid && rec_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push      = is_event && (!full || pop);
    assign drop      = is_event && full && !pop;

    assign rec_props = props_mem[rd_ptr];
    assign rec_ts    = ts_mem[rd_ptr];

    // Timestamp advances once per valid symbol and wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else if (run) begin
            ts <= ts + TS_W'(1);
        end
    end

    // FIFO storage is reset so the head outputs are never X when the FIFO is empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                props_mem[i] <= '0;
                ts_mem[i]    <= '0;
            end
        end else if (push) begin
            props_mem[wr_ptr] <= ev;
            ts_mem[wr_ptr]    <= ts;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky status and overflow; new bits win over a coincident clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky   <= '0;
            overflow <= 1'b0;
        end else begin
            sticky   <= (clear_sticky ? '0   : sticky)   | ev;
            overflow <= (clear_sticky ? 1'b0 : overflow) | drop;
        end
    end

endmodule

// File: tb/tb_monitor_verdict_collector.sv
// Self-checking bench for monitor_verdict_collector (default parameters).
// A queue model holds the records the design should contain. Records are pushed
// when an event is driven and are popped and compared when the consumer accepts
// the head record.

module tb_monitor_verdict_collector;

    localparam int NUM_PROPS = 10;
    localparam int TS_W      = 16;
    localparam int DEPTH     = 8;

    typedef struct packed {
        logic [NUM_PROPS-1:0] props;
        logic [TS_W-1:0]      ts;
    } rec_t;

    logic                 clk;
    logic                 reset;
    logic                 run;
    logic [NUM_PROPS-1:0] ltl_in;
    logic                 clear_sticky;
    logic                 rec_valid;
    logic                 rec_ready;
    logic [NUM_PROPS-1:0] rec_props;
    logic [TS_W-1:0]      rec_ts;
    logic [NUM_PROPS-1:0] sticky;
    logic                 overflow;
    logic [3:0]           count;

    int checks = 0;
    int errors = 0;

    rec_t                 q[$];
    logic [TS_W-1:0]      m_ts;
    logic [NUM_PROPS-1:0] m_sticky;
    logic                 m_overflow;
`ifdef VERDICT_EDGE_DETECT_EN
    logic [NUM_PROPS-1:0] m_prev;
`endif

    monitor_verdict_collector #(
        .NUM_PROPS(NUM_PROPS),
        .TS_W(TS_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .ltl_in(ltl_in),
        .clear_sticky(clear_sticky),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_props(rec_props),
        .rec_ts(rec_ts),
        .sticky(sticky),
        .overflow(overflow),
        .count(count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts       = '0;
        m_sticky   = '0;
        m_overflow = 1'b0;
`ifdef VERDICT_EDGE_DETECT_EN
        m_prev     = '0;
`endif
    endtask

    // Drive one cycle of inputs and update the model. Called #1 after a rising edge.
    // Returns #1 after the next rising edge.
    task automatic step(input logic r, input logic [NUM_PROPS-1:0] l, input logic rdy, input logic clr);
        logic [NUM_PROPS-1:0] ev;
        logic                 drop;
        rec_t                 head;
        run          = r;
        ltl_in       = l;
        rec_ready    = rdy;
        clear_sticky = clr;
        #1;
        ev = '0;
        if (r) begin
`ifdef VERDICT_EDGE_DETECT_EN
            ev = l & ~m_prev;
`else
            ev = l;
`endif
        end
        if (rdy && q.size() != 0) begin
            head = q.pop_front();
            check("pop_valid", 32'(rec_valid), 32'd1);
            check("pop_props", 32'(rec_props), 32'(head.props));
            check("pop_ts", 32'(rec_ts), 32'(head.ts));
        end
        drop = 1'b0;
        if (ev != '0) begin
            if (q.size() < DEPTH) q.push_back({ev, m_ts});
            else drop = 1'b1;
        end
        m_sticky   = (clr ? '0 : m_sticky) | ev;
        m_overflow = (clr ? 1'b0 : m_overflow) | drop;
        if (r) begin
            m_ts = m_ts + 16'd1;
`ifdef VERDICT_EDGE_DETECT_EN
            m_prev = l;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(q.size()));
        check({tag, "_valid"}, 32'(rec_valid), 32'(q.size() != 0));
        check({tag, "_sticky"}, 32'(sticky), 32'(m_sticky));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_overflow));
        if (q.size() != 0) begin
            check({tag, "_head_props"}, 32'(rec_props), 32'(q[0].props));
            check({tag, "_head_ts"}, 32'(rec_ts), 32'(q[0].ts));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        run          = 1'b0;
        ltl_in       = '0;
        rec_ready    = 1'b0;
        clear_sticky = 1'b0;
        reset        = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_head_known", 32'((^{rec_props, rec_ts}) !== 1'bx), 32'd1);
        reset = 1'b0;

        // Reset, then a single event after three idle run cycles
        repeat (3) step(1'b1, '0, 1'b0, 1'b0);
        step(1'b1, 10'h004, 1'b0, 1'b0);
        check_state("single");
        check("single_props", 32'(rec_props), 32'h004);
        check("single_ts", 32'(rec_ts), 32'd3);
        check("single_sticky", 32'(sticky), 32'h004);
        step(1'b0, '0, 1'b1, 1'b0);

        // Held verdict across four run cycles
        repeat (4) step(1'b1, 10'h201, 1'b0, 1'b0);
`ifdef VERDICT_EDGE_DETECT_EN
        check("held_count", 32'(count), 32'd1);
`else
        check("held_count", 32'(count), 32'd4);
`endif
        check_state("held");
        drain();
        step(1'b1, '0, 1'b0, 1'b1);

        // Nine events into an eight-deep FIFO, then a push while full with a pop
        for (int i = 0; i < 9; i++) step(1'b1, NUM_PROPS'(1 << i), 1'b0, 1'b0);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check_state("ovf");
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 10'h200, 1'b1, 1'b0);
        check("full_pop_count", 32'(count), 32'd8);
        check("full_pop_overflow", 32'(overflow), 32'd0);
        check_state("full_pop");
        drain();

        // Clear colliding with a new event
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 10'h003, 1'b0, 1'b0);
        check("pre_clear_sticky", 32'(sticky), 32'h003);
        step(1'b1, 10'h010, 1'b0, 1'b1);
        check("clear_collide_sticky", 32'(sticky), 32'h010);
        check_state("clear_collide");
        drain();

        // Asynchronous reset with five records pending
        step(1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, NUM_PROPS'(1 << i), 1'b0, 1'b0);
        check("midrst_pre_count", 32'(count), 32'd5);
        reset = 1'b1;
        #2;
        check("midrst_valid", 32'(rec_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 10'h080, 1'b0, 1'b0);
        check("midrst_ts_restart", 32'(rec_ts), 32'd0);
        check_state("midrst_after");
        drain();

        // Timestamp wrap: preload to 0xFFFF, then events on two consecutive cycles
        for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) step(1'b1, '0, 1'b1, 1'b0);
        check("wrap_preload_empty", 32'(count), 32'd0);
        step(1'b1, 10'h001, 1'b0, 1'b0);
        step(1'b1, 10'h002, 1'b0, 1'b0);
        check_state("wrap");
        check("wrap_ts_first", 32'(rec_ts), 32'hFFFF);
        step(1'b0, '0, 1'b1, 1'b0);
        check("wrap_ts_second", 32'(rec_ts), 32'h0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
